// File: rtl/sent_rx_frame_decoder_pkg.sv
// sent_rx_pkg: shared state encoding, CRC-4 table, seed default and the
// maximum data-nibble count for the SENT fast-channel frame decoder.
package sent_rx_pkg;

  localparam int         MAX_DATA     = 6;
  localparam logic [3:0] CRC_SEED_DEF = 4'h5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STATUS = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_CRC    = 3'd3;
  localparam logic [2:0] ST_PAUSE  = 3'd4;

  // T[i] lives at bits [4*i +: 4]; T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}
  localparam logic [63:0] CRC4_T = 64'h582F_B6C1_493E_A7D0;

  function automatic logic [3:0] crc4_lut(input logic [3:0] a);
    return CRC4_T[{a, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sent_rx_frame_decoder_if.sv
// Nibble-stream input and frame-result output bundle of the decoder.
// slave: decoder side; master: pulse checker / application side.
interface sent_rx_frame_decoder_if
  import sent_rx_pkg::*;
#(
  parameter int NUM_DATA = MAX_DATA
);

  logic                  sync_pulse;
  logic                  nib_valid;
  logic [3:0]            nib_data;
  logic                  pulse_err;
  logic                  frame_valid;
  logic [3:0]            frame_status;
  logic [4*NUM_DATA-1:0] frame_data;
  logic [3:0]            crc_rx;
  logic                  crc_error;
  logic                  frame_error;
  logic [15:0]           frame_cnt;

  modport master (
    output sync_pulse, nib_valid, nib_data, pulse_err,
    input  frame_valid, frame_status, frame_data, crc_rx,
    input  crc_error, frame_error, frame_cnt
  );

  modport slave (
    input  sync_pulse, nib_valid, nib_data, pulse_err,
    output frame_valid, frame_status, frame_data, crc_rx,
    output crc_error, frame_error, frame_cnt
  );

endinterface

// File: rtl/sent_rx_frame_decoder_crc4.sv
// sent_crc4_nibble: one SAE J2716 CRC-4 step, acc_o = T[acc_i] ^ nib_i.
// Ports: acc_i current accumulator, nib_i nibble (0 = augmentation), acc_o.
module sent_crc4_nibble
  import sent_rx_pkg::*;
(
  input  logic [3:0] acc_i,
  input  logic [3:0] nib_i,
  output logic [3:0] acc_o
);

  assign acc_o = crc4_lut(acc_i) ^ nib_i;

endmodule

// File: rtl/sent_rx_frame_decoder.sv
// SENT fast-channel frame decoder: status, NUM_DATA data, CRC (+ pause when
// SENT_RX_PAUSE_EN). Ports: clk_rx, reset (async high), bus (slave).
module sent_rx_frame_decoder
  import sent_rx_pkg::*;
#(
  parameter int         NUM_DATA = MAX_DATA,
  parameter logic [3:0] CRC_SEED = CRC_SEED_DEF
) (
  input logic                    clk_rx,
  input logic                    reset,
  sent_rx_frame_decoder_if.slave bus
);

  localparam int         DW   = 4 * NUM_DATA;
  localparam logic [2:0] LAST = 3'(NUM_DATA - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    acc_q, acc_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    stat_sh_q, stat_sh_d;
  logic [DW-1:0] data_sh_q, data_sh_d;
  logic [DW-1:0] data_shift;
  logic          err_d, done_d;

  logic          fv_q, fe_q, cerr_q;
  logic [3:0]    status_q, crc_q;
  logic [DW-1:0] data_q;
  logic [15:0]   cnt_q;

  logic [3:0]    acc_nxt, calc;
  logic          crc_bad;

  sent_crc4_nibble u_crc_data (
    .acc_i (acc_q),
    .nib_i (bus.nib_data),
    .acc_o (acc_nxt)
  );

  sent_crc4_nibble u_crc_aug (
    .acc_i (acc_q),
    .nib_i (4'h0),
    .acc_o (calc)
  );

  assign crc_bad = (bus.nib_data != calc);

  if (NUM_DATA > 1) begin : g_shift
    assign data_shift = {data_sh_q[DW-5:0], bus.nib_data};
  end else begin : g_one
    assign data_shift = bus.nib_data;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    stat_sh_d = stat_sh_q;
    data_sh_d = data_sh_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    if (bus.pulse_err && state_q != ST_IDLE) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (bus.sync_pulse) begin
      // a sync inside a frame aborts it; in IDLE/PAUSE it simply starts one
      err_d   = (state_q == ST_STATUS) || (state_q == ST_DATA) ||
                (state_q == ST_CRC);
      state_d = ST_STATUS;
      acc_d   = CRC_SEED;
      idx_d   = '0;
    end else if (bus.nib_valid) begin
      unique case (state_q)
        ST_STATUS: begin
          stat_sh_d = bus.nib_data;
          state_d   = ST_DATA;
          idx_d     = '0;
        end
        ST_DATA: begin
          data_sh_d = data_shift;
          acc_d     = acc_nxt;
          if (idx_q == LAST) state_d = ST_CRC;
          else               idx_d   = idx_q + 3'd1;
        end
        ST_CRC: begin
          done_d = 1'b1;
`ifdef SENT_RX_PAUSE_EN
          state_d = ST_PAUSE;
`else
          state_d = ST_IDLE;
`endif
        end
`ifdef SENT_RX_PAUSE_EN
        ST_PAUSE: state_d = ST_IDLE;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_rx or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= CRC_SEED;
      idx_q     <= '0;
      stat_sh_q <= '0;
      data_sh_q <= '0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
      status_q  <= '0;
      data_q    <= '0;
      crc_q     <= '0;
      cerr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      stat_sh_q <= stat_sh_d;
      data_sh_q <= data_sh_d;
      fv_q      <= done_d;
      fe_q      <= err_d;
      if (done_d) begin
        status_q <= stat_sh_q;
        data_q   <= data_sh_q;
        crc_q    <= bus.nib_data;
        cerr_q   <= crc_bad;
        if (!crc_bad) cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign bus.frame_valid  = fv_q;
  assign bus.frame_error  = fe_q;
  assign bus.frame_status = status_q;
  assign bus.frame_data   = data_q;
  assign bus.crc_rx       = crc_q;
  assign bus.crc_error    = cerr_q;
  assign bus.frame_cnt    = cnt_q;

endmodule

// File: tb/tb_sent_rx_frame_decoder.sv
// Randomized scoreboard bench for sent_rx_frame_decoder.
// Scenario-level model predicts frames/errors; a monitor compares them.
module tb_sent_rx_frame_decoder;

  localparam int ND = 6;

  typedef struct {
    logic [3:0]      st;
    logic [4*ND-1:0] d;
    logic [3:0]      crc;
    logic            ce;
    logic [15:0]     cnt;
    int              cyc;
  } exp_t;

  logic clk_rx = 1'b0;
  logic reset  = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t fq[$];
  int   eq[$];
  exp_t last;
  logic [15:0] mcnt = '0;

  always #5 clk_rx = ~clk_rx;
  always @(posedge clk_rx) cyc <= cyc + 1;

  sent_rx_frame_decoder_if #(.NUM_DATA(ND)) bus ();

  sent_rx_frame_decoder #(
    .NUM_DATA (ND),
    .CRC_SEED (4'h5)
  ) dut (
    .clk_rx (clk_rx),
    .reset  (reset),
    .bus    (bus)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // CRC straight from the J2716 rules: seed, table walk, zero augmentation
  function automatic logic [3:0] ref_crc(input logic [4*ND-1:0] d);
    int t[16] = '{0, 13, 7, 10, 14, 3, 9, 4, 1, 12, 6, 11, 15, 2, 8, 5};
    int a = 5;
    for (int i = ND - 1; i >= 0; i--) a = t[a] ^ int'(d[4*i +: 4]);
    return 4'(t[a]);
  endfunction

  task automatic step(input logic s, input logic v, input logic [3:0] n,
                      input logic e);
    bus.sync_pulse = s;
    bus.nib_valid  = v;
    bus.nib_data   = n;
    bus.pulse_err  = e;
    @(posedge clk_rx);
    #1;
    bus.sync_pulse = 1'b0;
    bus.nib_valid  = 1'b0;
    bus.pulse_err  = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic stray(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 4'($urandom), 1'b0);
      gap();
    end
  endtask

  // sync (unless already given), status, data, CRC; records prediction
  task automatic frame_crc(input bit skip_sync, input logic [3:0] st,
                           input logic [4*ND-1:0] d, input logic [3:0] crc);
    exp_t e;
    if (!skip_sync) begin
      // a nibble colliding with sync is always dropped
      step(1'b1, 1'($urandom), 4'($urandom), 1'b0);
      gap();
    end
    step(1'b0, 1'b1, st, 1'b0);
    gap();
    for (int i = 0; i < ND; i++) begin
      step(1'b0, 1'b1, d[4*(ND-1-i) +: 4], 1'b0);
      gap();
    end
    step(1'b0, 1'b1, crc, 1'b0);
    e.st  = st;
    e.d   = d;
    e.crc = crc;
    e.ce  = (crc != ref_crc(d));
    if (!e.ce) mcnt++;
    e.cnt = mcnt;
    e.cyc = cyc;
    fq.push_back(e);
  endtask

  task automatic frame_rand(input bit skip_sync);
    logic [4*ND-1:0] d;
    logic [3:0] c;
    d = (4*ND)'({$urandom, $urandom});
    c = ref_crc(d);
    if ($urandom_range(0, 3) == 0) c = c ^ 4'($urandom_range(1, 15));
    frame_crc(skip_sync, 4'($urandom), d, c);
  endtask

  // sync then k nibbles: k=0 STATUS, k=ND+1 parks in CRC
  task automatic partial(input int k);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    gap();
    for (int i = 0; i < k; i++) begin
      step(1'b0, 1'b1, 4'($urandom), 1'b0);
      gap();
    end
  endtask

  task automatic abort_sync(input int k);
    partial(k);
    step(1'b1, 1'($urandom), 4'($urandom), 1'b0);
    eq.push_back(cyc);
    gap();
    frame_rand(1'b1);
  endtask

  task automatic abort_perr(input int k);
    partial(k);
    step(1'($urandom), 1'($urandom), 4'($urandom), 1'b1);
    eq.push_back(cyc);
    gap();
    // IDLE now: nibbles and pulse errors are ignored
    stray($urandom_range(0, 3));
    step(1'b0, 1'b0, 4'h0, 1'b1);
    gap();
  endtask

  task automatic mid_reset(input int k);
    partial(k);
    reset = 1'b1;
    mcnt  = '0;
    last  = '{default: '0};
    repeat (2) @(posedge clk_rx);
    #1;
    check("rst_fv", 32'(bus.frame_valid), 32'h0);
    check("rst_cnt", 32'(bus.frame_cnt), 32'h0);
    check("rst_data", 32'(bus.frame_data), 32'h0);
    reset = 1'b0;
    gap();
  endtask

  always @(negedge clk_rx) begin
    exp_t e;
    if (!reset) begin
      if (bus.frame_valid) begin
        if (fq.size() == 0) begin
          check("unexpected_frame_valid", 32'h1, 32'h0);
        end else begin
          e = fq.pop_front();
          check("fv_cycle", 32'(cyc), 32'(e.cyc));
          check("fv_status", 32'(bus.frame_status), 32'(e.st));
          check("fv_data", 32'(bus.frame_data), 32'(e.d));
          check("fv_crc_rx", 32'(bus.crc_rx), 32'(e.crc));
          check("fv_crc_error", 32'(bus.crc_error), 32'(e.ce));
          check("fv_cnt", 32'(bus.frame_cnt), 32'(e.cnt));
          last = e;
        end
      end else begin
        check("hold_status", 32'(bus.frame_status), 32'(last.st));
        check("hold_data", 32'(bus.frame_data), 32'(last.d));
        check("hold_crc_error", 32'(bus.crc_error), 32'(last.ce));
        check("hold_cnt", 32'(bus.frame_cnt), 32'(last.cnt));
      end
      if (bus.frame_error) begin
        if (eq.size() == 0) check("unexpected_frame_error", 32'h1, 32'h0);
        else check("fe_cycle", 32'(cyc), 32'(eq.pop_front()));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    last           = '{default: '0};
    bus.sync_pulse = 1'b0;
    bus.nib_valid  = 1'b0;
    bus.nib_data   = 4'h0;
    bus.pulse_err  = 1'b0;
    repeat (3) @(posedge clk_rx);
    #1;
    check("reset_fv", 32'(bus.frame_valid), 32'h0);
    check("reset_fe", 32'(bus.frame_error), 32'h0);
    check("reset_status", 32'(bus.frame_status), 32'h0);
    check("reset_data", 32'(bus.frame_data), 32'h0);
    check("reset_crc", 32'(bus.crc_rx), 32'h0);
    check("reset_cnt", 32'(bus.frame_cnt), 32'h0);
    reset = 1'b0;
    gap();

    stray(2);
    frame_crc(1'b0, 4'h3, '0, 4'h5);
    frame_crc(1'b0, 4'h3, '0, 4'h6);
    abort_sync(4);
    abort_perr(3);
    step(1'b1, 1'b1, 4'hA, 1'b0);
    frame_rand(1'b1);
    frame_rand(1'b0);
    stray(1);
    frame_rand(1'b0);
    frame_rand(1'b0);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 5))
        0:       abort_sync($urandom_range(0, ND + 1));
        1:       abort_perr($urandom_range(0, ND + 1));
        2:       mid_reset($urandom_range(0, ND + 1));
        default: begin
          frame_rand(1'b0);
          stray($urandom_range(0, 2));
        end
      endcase
    end

    repeat (4) step(1'b0, 1'b0, 4'h0, 1'b0);
    check("frames_pending", 32'(fq.size()), 32'h0);
    check("errors_pending", 32'(eq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sent_rx_frame_decoder.md
Name: sent_rx_frame_decoder

Overview:
- Downstream of the SENT pulse checker. Consumes its sync events and decoded 4-bit nibbles, all on clk_rx.
- Assembles one fast-channel frame: status nibble, NUM_DATA data nibbles, CRC nibble, optional pause.
- Checks the SAE J2716 CRC-4 and presents the frame payload plus error flags to the application layer.

Parameters:
- NUM_DATA, 6, data nibbles per frame; legal range 1..6.
- CRC_SEED, 4'h5, CRC-4 initial value.

Ports:
- clk_rx  in  1  receive clock
- reset  in  1  asynchronous, active-high reset
- sync_pulse  in  1  one-cycle strobe: valid sync pulse ended
- nib_valid  in  1  one-cycle strobe: nib_data holds a decoded nibble
- nib_data  in  4  nibble value, 0..15
- pulse_err  in  1  one-cycle strobe: upstream pulse width out of range
- frame_valid  out  1  one-cycle strobe: new frame registered on outputs
- frame_status  out  4  status/communication nibble
- frame_data  out  4*NUM_DATA  data nibbles; first received nibble in the MSBs
- crc_rx  out  4  received CRC nibble
- crc_error  out  1  crc_rx differed from the computed CRC; valid with frame_valid
- frame_error  out  1  one-cycle strobe: frame aborted
- frame_cnt  out  16  good-frame counter; wraps 16'hFFFF to 0

Behaviour:
- Reset: all outputs 0, FSM in IDLE, CRC accumulator = CRC_SEED, nibble index = 0.
- FSM states: IDLE, STATUS, DATA, CRC, PAUSE.
- IDLE: ignore nib_valid. On sync_pulse go to STATUS and load CRC accumulator = CRC_SEED.
- STATUS: on nib_valid, store the status nibble in a shadow register and go to DATA with index = 0. The status nibble is excluded from the CRC.
- DATA: on nib_valid, shift the nibble into the shadow data register and update acc = T[acc] ^ nib_data.
  - T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}, indexed by acc.
  - Increment index. When index reaches NUM_DATA-1 on an accepted nibble, go to CRC.
- CRC: on nib_valid, compute calc = T[acc] (zero-nibble augmentation).
  - Next cycle, register the shadow registers to frame_status, frame_data and crc_rx.
  - In the same next cycle: crc_error = (nib_data != calc), pulse frame_valid, and increment frame_cnt only if there is no CRC error.
  - Latency is one clk_rx cycle from the CRC nib_valid to frame_valid.
  - Then go to PAUSE if SENT_RX_PAUSE_EN is defined, otherwise go to IDLE awaiting sync.
- Output registers hold their values between frame_valid strobes. crc_error holds until the next frame_valid.
- Sync in STATUS, DATA or CRC: frame_error pulses and the FSM restarts at STATUS with the CRC reseeded (early sync). Shadow data is discarded and outputs are unchanged.
- sync_pulse and nib_valid in the same cycle: sync wins and the nibble is dropped.
- pulse_err in any state except IDLE: frame_error pulses and the FSM goes to IDLE. pulse_err has priority over sync_pulse and nib_valid.
- nib_valid in IDLE: ignored, no error.
- Reset mid-frame: immediate return to the reset state; no frame_valid is emitted.

Optional Feature:
- Macro: SENT_RX_PAUSE_EN.
- Defined: after CRC the FSM enters PAUSE.
  - The first nib_valid in PAUSE is accepted as the pause pulse and the FSM goes to IDLE.
  - sync_pulse in PAUSE behaves like IDLE+sync (pause omitted), with no error.
  - A second nib_valid before sync is absorbed by IDLE.
- Undefined: the PAUSE state is not built; CRC goes directly to IDLE.

Decomposition:
- Shared package sent_rx_pkg holds:
  - the FSM state enum;
  - the CRC-4 table constant T;
  - CRC_SEED default;
  - max data nibbles (6).
- One sub-module, sent_crc4_nibble: combinational table lookup giving next_acc = T[acc] ^ nib. It is reused with nib = 0 for augmentation.

Test Plan:
- sync, status 4'h3, data 0,0,0,0,0,0, CRC 4'h5 -> frame_valid one cycle after the CRC strobe; frame_data = 24'h000000, frame_status = 3, crc_error = 0, frame_cnt = 1.
- Same frame with CRC 4'h6 -> frame_valid = 1, crc_error = 1, frame_cnt unchanged.
- sync, status, 3 data nibbles, then sync -> frame_error pulse, FSM in STATUS; the next full valid frame is decoded correctly.
- pulse_err during DATA -> frame_error pulse, FSM in IDLE; nibbles before the next sync are ignored and no frame_valid occurs.
- sync_pulse and nib_valid asserted in the same cycle during IDLE -> the nibble is dropped and the following nibble is taken as status.
- SENT_RX_PAUSE_EN defined: two frames, the first with a pause nibble and the second without -> two frame_valid strobes and no frame_error.
